// File: rtl/stopwatch_pkg.sv
// Shared state encoding and default sizing for the stopwatch run/pause/clear sequencer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_CLEAR = 2'd3
    } sw_state_t;

    localparam int SW_CLK_DIV = 100000000;
    localparam int SW_DIV_BIT = 27;
    localparam int SW_SEC_BIT = 6;
    localparam int SW_MIN_BIT = 6;

endpackage

// File: rtl/stopwatch_prescaler.sv
// Base-tick prescaler: counts clk cycles while enabled, holds otherwise, and flags
// the terminal count (P_CLK_DIV-1) straight from the counter register.
module stopwatch_prescaler
    import stopwatch_pkg::*;
#(
    parameter int P_CLK_DIV = SW_CLK_DIV,
    parameter int P_DIV_BIT = SW_DIV_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_cnt_en,
    input  logic i_cnt_clr,
    output logic o_term
);

    localparam logic [P_DIV_BIT-1:0] TERM_CNT = P_DIV_BIT'(P_CLK_DIV - 1);

    logic [P_DIV_BIT-1:0] div_cnt_reg;
    logic [P_DIV_BIT-1:0] div_cnt_next;

    // Clear dominates enable; a disabled counter keeps its partial period.
    always_comb begin
        div_cnt_next = div_cnt_reg;
        if (i_cnt_clr) begin
            div_cnt_next = '0;
        end else if (i_cnt_en) begin
            div_cnt_next = (div_cnt_reg == TERM_CNT) ? '0 : div_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_next;
        end
    end

    assign o_term = (div_cnt_reg == TERM_CNT);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer with base-tick generation and lap-hold display path.
// Lap-hold logic is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int P_CLK_DIV = SW_CLK_DIV,
    parameter int P_DIV_BIT = SW_DIV_BIT,
    parameter int P_SEC_BIT = SW_SEC_BIT,
    parameter int P_MIN_BIT = SW_MIN_BIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_btn_run,
    input  logic                 i_btn_clr,
    input  logic                 i_btn_lap,
    input  logic [P_SEC_BIT-1:0] i_sec_val,
    input  logic [P_MIN_BIT-1:0] i_min_val,
    output logic                 o_run_en,
    output logic                 o_tick,
    output logic                 o_cnt_clr,
    output logic [1:0]           o_state,
    output logic                 o_lap_valid,
    output logic [P_SEC_BIT-1:0] o_disp_sec,
    output logic [P_MIN_BIT-1:0] o_disp_min
);

    sw_state_t state_reg;
    sw_state_t state_next;
    logic      div_term;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE, ST_PAUSE: begin
                if (i_btn_clr) begin
                    state_next = ST_CLEAR;
                end else if (i_btn_run) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_btn_run) begin
                    state_next = ST_PAUSE;
                end
            end
            ST_CLEAR: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    stopwatch_prescaler #(
        .P_CLK_DIV (P_CLK_DIV),
        .P_DIV_BIT (P_DIV_BIT)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .i_cnt_en  (state_reg == ST_RUN),
        .i_cnt_clr (state_reg == ST_CLEAR),
        .o_term    (div_term)
    );

    // Tick is gated by the registered state, so it can never appear without run enable.
    assign o_run_en  = (state_reg == ST_RUN);
    assign o_tick    = (state_reg == ST_RUN) && div_term;
    assign o_cnt_clr = (state_reg == ST_CLEAR);
    assign o_state   = state_reg;

    logic                 lap_valid_reg;
    logic                 lap_valid_next;
    logic [P_SEC_BIT-1:0] disp_sec_reg;
    logic [P_SEC_BIT-1:0] disp_sec_next;
    logic [P_MIN_BIT-1:0] disp_min_reg;
    logic [P_MIN_BIT-1:0] disp_min_next;

`ifdef STOPWATCH_LAP_EN
    logic lap_capture;
    assign lap_capture = i_btn_lap && (state_reg == ST_RUN);

    // A capture loads the live value; otherwise the display follows unless held.
    always_comb begin
        lap_valid_next = lap_valid_reg;
        disp_sec_next  = disp_sec_reg;
        disp_min_next  = disp_min_reg;
        if (state_reg == ST_CLEAR) begin
            lap_valid_next = 1'b0;
        end else if (i_btn_lap) begin
            lap_valid_next = lap_capture;
        end
        if (!lap_valid_next || lap_capture) begin
            disp_sec_next = i_sec_val;
            disp_min_next = i_min_val;
        end
    end
`else
    logic lap_unused;
    assign lap_unused = i_btn_lap;

    always_comb begin
        lap_valid_next = 1'b0;
        disp_sec_next  = i_sec_val;
        disp_min_next  = i_min_val;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            lap_valid_reg <= 1'b0;
            disp_sec_reg  <= '0;
            disp_min_reg  <= '0;
        end else begin
            lap_valid_reg <= lap_valid_next;
            disp_sec_reg  <= disp_sec_next;
            disp_min_reg  <= disp_min_next;
        end
    end

    assign o_lap_valid = lap_valid_reg;
    assign o_disp_sec  = disp_sec_reg;
    assign o_disp_min  = disp_min_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed scoreboard bench for stopwatch_ctrl with P_CLK_DIV=4; lap expectations
// follow whether STOPWATCH_LAP_EN is defined for the build.
module tb_stopwatch_ctrl;

    localparam int P_CLK_DIV = 4;
    localparam int P_DIV_BIT = 3;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif
    localparam logic [1:0] S_I = 2'd0;
    localparam logic [1:0] S_R = 2'd1;
    localparam logic [1:0] S_P = 2'd2;
    localparam logic [1:0] S_C = 2'd3;
    localparam int HELD = LAP ? 17 : -1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_btn_run = 1'b0;
    logic       i_btn_clr = 1'b0;
    logic       i_btn_lap = 1'b0;
    logic [5:0] i_sec_val = '0;
    logic [5:0] i_min_val = '0;
    logic       o_run_en;
    logic       o_tick;
    logic       o_cnt_clr;
    logic [1:0] o_state;
    logic       o_lap_valid;
    logic [5:0] o_disp_sec;
    logic [5:0] o_disp_min;

    typedef struct {
        logic [1:0] st;
        logic       tick;
        logic       lapv;
        logic       chk_disp;
        logic [5:0] sec;
        logic [5:0] min;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         txn = 0;
    logic [5:0] sec_in = '0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .P_CLK_DIV (P_CLK_DIV),
        .P_DIV_BIT (P_DIV_BIT),
        .P_SEC_BIT (6),
        .P_MIN_BIT (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_btn_run   (i_btn_run),
        .i_btn_clr   (i_btn_clr),
        .i_btn_lap   (i_btn_lap),
        .i_sec_val   (i_sec_val),
        .i_min_val   (i_min_val),
        .o_run_en    (o_run_en),
        .o_tick      (o_tick),
        .o_cnt_clr   (o_cnt_clr),
        .o_state     (o_state),
        .o_lap_valid (o_lap_valid),
        .o_disp_sec  (o_disp_sec),
        .o_disp_min  (o_disp_min)
    );

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL txn=%0d %s actual=%0d required=%0d", txn, name, act, req);
        end
    endtask

    // e_sec: >=0 explicit held value, -1 follows the value driven this step,
    // -2 reset zeros, -3 display not checked.
    task automatic step(input logic rst, input logic run, input logic clr, input logic lap,
                        input logic [1:0] e_st, input logic e_tick, input logic e_lap,
                        input int e_sec);
        exp_t e;
        @(negedge clk);
        sec_in    = sec_in + 6'd1;
        reset     = rst;
        i_btn_run = run;
        i_btn_clr = clr;
        i_btn_lap = lap;
        i_sec_val = sec_in;
        i_min_val = sec_in ^ 6'h2A;
        e.st       = e_st;
        e.tick     = e_tick;
        e.lapv     = e_lap;
        e.chk_disp = (e_sec != -3);
        if (e_sec == -2) begin
            e.sec = '0;
            e.min = '0;
        end else begin
            e.sec = (e_sec == -1) ? sec_in : 6'(e_sec);
            e.min = e.sec ^ 6'h2A;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents a fresh output set after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                $display("txn=%0d state=%0d run_en=%0b tick=%0b clr=%0b lap=%0b sec=%0d min=%0d",
                         txn, o_state, o_run_en, o_tick, o_cnt_clr, o_lap_valid, o_disp_sec, o_disp_min);
                cmp("state", int'(o_state), int'(e.st));
                cmp("run_en", int'(o_run_en), int'(e.st == S_R));
                cmp("cnt_clr", int'(o_cnt_clr), int'(e.st == S_C));
                cmp("tick", int'(o_tick), int'(e.tick));
                cmp("lap_valid", int'(o_lap_valid), int'(e.lapv));
                if (e.chk_disp) begin
                    cmp("disp_sec", int'(o_disp_sec), int'(e.sec));
                    cmp("disp_min", int'(o_disp_min), int'(e.min));
                end
            end
        end
    end

    initial begin
        // Reset and start: ticks in RUN cycles 4, 8, 12
        step(1, 0, 0, 0, S_I, 0, 0, -2);
        step(1, 0, 0, 0, S_I, 0, 0, -2);
        step(0, 0, 0, 0, S_I, 0, 0, -1);
        step(0, 1, 0, 0, S_R, 0, 0, -1);
        for (int c = 2; c <= 12; c++) step(0, 0, 0, 0, S_R, (c % 4 == 0), 0, -1);
        // Pause sampled at div_cnt=2, resume ticks immediately
        step(0, 0, 0, 0, S_R, 0, 0, -1);
        step(0, 0, 0, 0, S_R, 0, 0, -1);
        step(0, 0, 0, 0, S_R, 0, 0, -1);
        step(0, 1, 0, 0, S_P, 0, 0, -1);
        for (int c = 0; c < 3; c++) step(0, 0, 0, 0, S_P, 0, 0, -1);
        step(0, 1, 0, 0, S_R, 1, 0, -1);
        for (int c = 1; c <= 4; c++) step(0, 0, 0, 0, S_R, (c == 4), 0, -1);
        // Clear ignored in RUN, honoured in PAUSE, counter restarts from zero
        step(0, 0, 1, 0, S_R, 0, 0, -1);
        step(0, 0, 0, 0, S_R, 0, 0, -1);
        step(0, 1, 0, 0, S_P, 0, 0, -1);
        step(0, 0, 1, 0, S_C, 0, 0, -1);
        step(0, 0, 0, 0, S_I, 0, 0, -1);
        step(0, 1, 0, 0, S_R, 0, 0, -1);
        for (int c = 2; c <= 4; c++) step(0, 0, 0, 0, S_R, (c == 4), 0, -1);
        // run+clr in PAUSE: clear wins
        step(0, 1, 0, 0, S_P, 0, 0, -1);
        step(0, 1, 1, 0, S_C, 0, 0, -1);
        step(0, 0, 0, 0, S_I, 0, 0, -1);
        step(0, 0, 0, 0, S_I, 0, 0, -1);
        // Lap capture of 17 in RUN, held while input advances to 20
        step(0, 1, 0, 0, S_R, 0, 0, -1);
        sec_in = 6'd16;
        step(0, 0, 0, 1, S_R, 0, LAP, HELD);
        step(0, 0, 0, 0, S_R, 0, LAP, HELD);
        step(0, 0, 0, 0, S_R, 1, LAP, HELD);
        step(0, 0, 0, 0, S_R, 0, LAP, HELD);
        step(0, 1, 0, 0, S_P, 0, LAP, HELD);
        step(0, 0, 0, 1, S_P, 0, 0, -3);
        step(0, 0, 0, 0, S_P, 0, 0, -1);
        // Reset in a tick cycle, then restart from div_cnt=0
        step(0, 1, 0, 0, S_R, 0, 0, -1);
        step(0, 0, 0, 0, S_R, 0, 0, -1);
        step(0, 0, 0, 0, S_R, 1, 0, -1);
        step(1, 1, 1, 1, S_I, 0, 0, -2);
        step(0, 0, 0, 0, S_I, 0, 0, -1);
        step(0, 1, 0, 0, S_R, 0, 0, -1);
        for (int c = 2; c <= 4; c++) step(0, 0, 0, 0, S_R, (c == 4), 0, -1);
        step(0, 0, 0, 0, S_R, 0, 0, -1);

        repeat (3) @(posedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
